// File: rtl/pipe_fetch_stage.sv
// pipe_fetch_stage: PC register, redirect target selection and IF/ID pipeline register
module pipe_fetch_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0000,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [1:0]        redirect_sel,
  input  logic [DATA_W-1:0] redirect_pc4,
  input  logic [DATA_W-1:0] redirect_imm,
  input  logic [25:0]       redirect_index,
  input  logic [DATA_W-1:0] redirect_rs,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic [DATA_W-1:0] imem_addr,
  output logic [31:0]       if_id_inst,
  output logic [DATA_W-1:0] if_id_pc4,
  output logic              if_id_valid,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  stall_cycles
);
  logic [DATA_W-1:0] r_pc, r_pc4, w_pc4, w_br, w_jmp, w_tgt;
  logic [31:0]       r_inst;
  logic              r_valid, r_mis;
  logic [CNT_W-1:0]  r_cnt;
  assign w_pc4 = r_pc + DATA_W'(4);
  assign w_br  = redirect_pc4 + (redirect_imm << 2);
  assign w_jmp = {redirect_pc4[DATA_W-1:28], redirect_index, 2'b00};
  assign w_tgt = redirect_sel == 2'b01 ? w_br :
                 redirect_sel == 2'b10 ? w_jmp :
                 redirect_sel == 2'b11 ? redirect_rs : redirect_pc4;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      r_cnt   <= '0;
    end else if (redirect) begin
      r_pc    <= {w_tgt[DATA_W-1:2], 2'b00};
      r_inst  <= NOP_INST;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_mis   <= |w_tgt[1:0];
    end else begin
      r_mis <= 1'b0;
      // both hazard stalls and imem waits count as cycles without PC progress
      if (stall || !imem_ready)
        r_cnt <= r_cnt + CNT_W'(r_cnt != '1);
      if (!stall && !imem_ready) begin
        r_inst  <= NOP_INST;
        r_pc4   <= '0;
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_pc    <= w_pc4;
        r_inst  <= imem_rdata;
        r_pc4   <= w_pc4;
        r_valid <= 1'b1;
      end
    end
  end
  assign imem_addr    = r_pc;
  assign if_id_inst   = r_inst;
  assign if_id_pc4    = r_pc4;
  assign if_id_valid  = r_valid;
  assign misalign_err = r_mis;
  assign stall_cycles = r_cnt;
endmodule

// File: tb/tb_pipe_fetch_stage.sv
// tb_pipe_fetch_stage: directed and random stimulus, queue scoreboard against a behavioural fetch model
module tb_pipe_fetch_stage;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0400;
  localparam logic [31:0] NOP      = 32'h0000_0020;

  typedef struct {
    logic [31:0]      pc, inst, pc4;
    logic             valid, mis;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 0, rst = 0, stall = 0, redirect = 0, imem_ready = 1;
  logic [1:0]  redirect_sel = 0;
  logic [31:0] redirect_pc4 = 0, redirect_imm = 0, redirect_rs = 0, imem_rdata = 0;
  logic [25:0] redirect_index = 0;
  logic [31:0] imem_addr, if_id_inst, if_id_pc4;
  logic        if_id_valid, misalign_err;
  logic [CNT_W-1:0] stall_cycles;

  pipe_fetch_stage #(.DATA_W(32), .RESET_PC(RESET_PC), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_sel(redirect_sel),
    .redirect_pc4(redirect_pc4), .redirect_imm(redirect_imm), .redirect_index(redirect_index),
    .redirect_rs(redirect_rs), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_addr(imem_addr), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .misalign_err(misalign_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  exp_t m;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus: drive inputs after the falling edge and queue what
  // the outputs must show after the following rising edge.
  task automatic tick(input logic r, st, rd, input logic [1:0] sl, input logic [31:0] p4, im,
                      input logic [25:0] ix, input logic [31:0] rsv, rdat, input logic rdy);
    logic [31:0] t;
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_sel = sl; redirect_pc4 = p4;
    redirect_imm = im; redirect_index = ix; redirect_rs = rsv; imem_rdata = rdat; imem_ready = rdy;
    if (!r) begin
      m.pc = RESET_PC; m.inst = NOP; m.pc4 = 0; m.valid = 0; m.mis = 0; m.cnt = 0;
    end else if (rd) begin
      case (sl)
        2'b01:   t = p4 + im * 4;
        2'b10:   t = (p4 & 32'hF000_0000) | (32'(ix) * 4);
        2'b11:   t = rsv;
        default: t = p4;
      endcase
      m.mis = (t % 4) != 0;
      m.pc = t - (t % 4); m.inst = NOP; m.pc4 = 0; m.valid = 0;
    end else begin
      m.mis = 0;
      if (st || !rdy) m.cnt = (m.cnt == CNT_W'((1 << CNT_W) - 1)) ? m.cnt : m.cnt + 1'b1;
      if (!st && !rdy) begin
        m.inst = NOP; m.pc4 = 0; m.valid = 0;
      end else if (!st) begin
        m.pc = m.pc + 4; m.inst = rdat; m.pc4 = m.pc; m.valid = 1;
      end
    end
    q.push_back(m);
  endtask

  task automatic run(input logic st, input logic rdy);
    tick(1, st, 0, 0, 0, 0, 0, 0, $urandom, rdy);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("imem_addr", imem_addr, e.pc);
      chk("if_id_inst", if_id_inst, e.inst);
      chk("if_id_pc4", if_id_pc4, e.pc4);
      chk("if_id_valid", 32'(if_id_valid), 32'(e.valid));
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    end
  end

  initial begin
    m = '{pc: 0, inst: 0, pc4: 0, valid: 0, mis: 0, cnt: 0};
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(0, 1, 1, 2'b11, 0, 0, 0, 32'h1234, 0, 0);
    run(0, 1); run(0, 1);
    repeat (3) run(1, 1);
    run(0, 1);
    tick(1, 1, 1, 2'b01, 32'h0000_1000, 32'hFFFF_FFFF, 0, 0, 0, 1);
    run(0, 1);
    tick(1, 0, 1, 2'b10, 32'hA000_0010, 0, 26'h0000123, 0, 0, 1);
    tick(1, 0, 1, 2'b11, 0, 0, 0, 32'h0000_2002, 0, 0);
    run(0, 1);
    run(0, 0); run(0, 0);
    run(0, 1);
    tick(1, 0, 1, 2'b11, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    run(0, 1); run(0, 1);
    tick(1, 0, 1, 2'b00, 32'h0000_0033, 0, 0, 0, 0, 1);
    repeat (20) run(1, $urandom_range(0, 1));
    tick(0, 1, 1, 2'b01, $urandom, $urandom, 0, 0, $urandom, 0);
    run(0, 1);
    repeat (400) begin
      tick(($urandom % 32) != 0, ($urandom % 4) == 0, ($urandom % 6) == 0, 2'($urandom),
           $urandom, $urandom, 26'($urandom), $urandom, $urandom, ($urandom % 4) != 0);
    end
    @(negedge clk);
    rst = 1; stall = 1; redirect = 0;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
